regfile_sb: RTL
===============

# regfile_sb

Parametrised successor to the 8×16 datapath register file: DEPTH×WIDTH storage with one write port, two registered read ports (1-cycle latency), synchronous active-low clear, optional hardwired zero register, and a per-register busy scoreboard for pending writebacks. Sits between decode (reserve, read) and writeback (write). Exposes a flattened debug view of all registers for the bench and top-level probes.

## Interface
- WIDTH, 16, data width in bits (≥1)
- DEPTH, 8, number of registers; power of two, ≥2; AW = $clog2(DEPTH)
- ZERO_REG, 0, 1 = register 0 reads as 0 and ignores writes/reserves

- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset, synchronous, active-low
- wr_en  in  1  writeback strobe
- wr_addr  in  AW  writeback register index
- wr_data  in  WIDTH  writeback data
- resv_en  in  1  mark register as pending (producer issued)
- resv_addr  in  AW  register to reserve
- rd_en  in  1  read request, both ports
- a_addr  in  AW  port A index
- b_addr  in  AW  port B index
- a_data  out  WIDTH  port A data, registered
- b_data  out  WIDTH  port B data, registered
- a_busy  out  1  port A register pending, registered with a_data
- b_busy  out  1  port B register pending, registered with b_data
- rd_valid  out  1  one-cycle pulse: a/b outputs updated this cycle
- busy_vec  out  DEPTH  live scoreboard, bit i = register i pending
- regs_flat  out  WIDTH*DEPTH  live storage; register i at [i*WIDTH +: WIDTH]

## Operation
- Reset (rst_n=0 at edge): all registers 0, busy_vec 0, a_data/b_data 0, a_busy/b_busy 0, rd_valid 0. Reset overrides every other input that edge.
- Write: wr_en=1 → reg[wr_addr] ← wr_data, busy[wr_addr] ← 0.
- Reserve: resv_en=1 → busy[resv_addr] ← 1.
- Same-edge write and reserve, same address: data written, busy ends 1 (new producer wins). Different addresses: both apply.
- ZERO_REG=1: writes/reserves to index 0 dropped; reg[0] and busy[0] stay 0.
- Read: rd_en=1 → a_data ← value of reg[a_addr], a_busy ← next-state busy[a_addr] (after this edge's write/reserve); same for B; rd_valid ← 1.
- rd_en=0 → a_data, b_data, a_busy, b_busy hold; rd_valid ← 0.
- a_addr == b_addr permitted; both ports return identical values.
- Addresses always in range (AW bits, DEPTH power of two); no wrap logic needed.
- busy_vec, regs_flat: direct combinational views of current state, no bypass.

## Timing
- Write/reserve visible on busy_vec/regs_flat the cycle after the edge.
- Read latency: 1 cycle; request at edge N, data and rd_valid valid after edge N, until edge N+1.
- Back-to-back reads every cycle supported; rd_valid stays high.
- Same-cycle read and write of the same address: see Configuration.
- Reset mid-operation: in-flight read discarded; rd_valid 0 and outputs 0 the cycle after reset edge.

## Configuration
- REGFILE_BYPASS_EN defined: same-edge rd_en and wr_en with a_addr==wr_addr (and not the zero reg when ZERO_REG=1) → a_data ← wr_data; same for B. Read returns the new value.
- Not defined: read returns the pre-write storage value; new value seen on the next read. Busy reporting identical in both builds.

## Test plan
- Reset: drive random inputs with rst_n=0 for 3 cycles → all outputs 0, regs_flat 0, busy_vec 0.
- Write 0x1234 to r5, next cycle rd_en a_addr=5 b_addr=0 → one cycle later a_data=0x1234, b_data=0, rd_valid=1 for exactly one cycle.
- Same cycle wr_en r3=0xBEEF, rd_en a_addr=3 (r3 previously 0x0001) → a_data=0xBEEF with REGFILE_BYPASS_EN, 0x0001 without.
- resv r2, read r2 → a_busy=1, busy_vec[2]=1; then write r2=0x00AA with resv r2 same edge → busy stays 1; write alone next → busy_vec[2]=0.
- ZERO_REG=1: write 0xFFFF and reserve r0 → reading r0 gives 0, a_busy=0, busy_vec[0]=0.
- rd_en one cycle, rst_n=0 next edge → rd_valid=0, a_data=0 after reset; WIDTH=32, DEPTH=32 build passes the same sequence.

Source files
------------

// File: rtl/regfile_sb.sv
// DEPTH x WIDTH register file with one write port, two registered read ports and a per-register
// busy scoreboard. Define REGFILE_BYPASS_EN to forward same-edge write data to the read ports.
module regfile_sb #(
  parameter int   WIDTH    = 16,
  parameter int   DEPTH    = 8,
  parameter bit   ZERO_REG = 1'b0,
  localparam int  AW       = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [AW-1:0]          wr_addr,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   resv_en,
  input  logic [AW-1:0]          resv_addr,
  input  logic                   rd_en,
  input  logic [AW-1:0]          a_addr,
  input  logic [AW-1:0]          b_addr,
  output logic [WIDTH-1:0]       a_data,
  output logic [WIDTH-1:0]       b_data,
  output logic                   a_busy,
  output logic                   b_busy,
  output logic                   rd_valid,
  output logic [DEPTH-1:0]       busy_vec,
  output logic [WIDTH*DEPTH-1:0] regs_flat
);

  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [WIDTH-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0] busy_q, busy_d;
  logic [WIDTH-1:0] a_data_q, a_data_d;
  logic [WIDTH-1:0] b_data_q, b_data_d;
  logic             a_busy_q, a_busy_d;
  logic             b_busy_q, b_busy_d;
  logic             rd_valid_q, rd_valid_d;
  logic             wr_ok;
  logic             resv_ok;

  // Register 0 is read-only zero when ZERO_REG is set, so its strobes are masked here.
  always_comb begin
    wr_ok   = wr_en && !(ZERO_REG && (wr_addr == '0));
    resv_ok = resv_en && !(ZERO_REG && (resv_addr == '0));
    regs_d  = regs_q;
    busy_d  = busy_q;
    if (wr_ok) begin
      regs_d[wr_addr] = wr_data;
      busy_d[wr_addr] = 1'b0;
    end
    // Reserve after write: a new producer on the same edge leaves the register pending.
    if (resv_ok) begin
      busy_d[resv_addr] = 1'b1;
    end
  end

  always_comb begin
    a_data_d   = a_data_q;
    b_data_d   = b_data_q;
    a_busy_d   = a_busy_q;
    b_busy_d   = b_busy_q;
    rd_valid_d = rd_en;
    if (rd_en) begin
      a_data_d = regs_q[a_addr];
      b_data_d = regs_q[b_addr];
`ifdef REGFILE_BYPASS_EN
      if (wr_ok && (a_addr == wr_addr)) a_data_d = wr_data;
      if (wr_ok && (b_addr == wr_addr)) b_data_d = wr_data;
`endif
      // Busy is reported after this edge's write/reserve in both builds.
      a_busy_d = busy_d[a_addr];
      b_busy_d = busy_d[b_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
      busy_q     <= '0;
      a_data_q   <= '0;
      b_data_q   <= '0;
      a_busy_q   <= 1'b0;
      b_busy_q   <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      regs_q     <= regs_d;
      busy_q     <= busy_d;
      a_data_q   <= a_data_d;
      b_data_q   <= b_data_d;
      a_busy_q   <= a_busy_d;
      b_busy_q   <= b_busy_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign a_data   = a_data_q;
  assign b_data   = b_data_q;
  assign a_busy   = a_busy_q;
  assign b_busy   = b_busy_q;
  assign rd_valid = rd_valid_q;
  assign busy_vec = busy_q;

  for (genvar g = 0; g < DEPTH; g++) begin : g_flat
    assign regs_flat[g*WIDTH +: WIDTH] = regs_q[g];
  end

endmodule
